// File: rtl/config_reg_file_if.sv
// Val/rdy message channel used on both sides of the configuration chain.
// The master drives msg/val; the slave answers with rdy.
interface config_reg_file_if #(
    parameter int MSG_W = 13
);
    logic [MSG_W-1:0] msg;
    logic             val;
    logic             rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/config_reg_file.sv
// Bank of NUM_REGS configuration registers at [BASE_ADDR, BASE_ADDR+NUM_REGS)
// on a val/rdy message chain with a one-entry registered output buffer.
module config_reg_file #(
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8,
    parameter int NUM_REGS     = 4,
    parameter int BASE_ADDR    = 0,
    localparam int MSG_W       = ADDR_SIZE + PAYLOAD_SIZE + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    config_reg_file_if.slave                 recv,
    config_reg_file_if.master                send,
    output logic [NUM_REGS*PAYLOAD_SIZE-1:0] cfg_out
);

    // Window bounds carry one extra bit so BASE_ADDR+NUM_REGS never wraps.
    localparam logic [ADDR_SIZE:0] WIN_LO = (ADDR_SIZE+1)'(BASE_ADDR);
    localparam logic [ADDR_SIZE:0] WIN_HI = (ADDR_SIZE+1)'(BASE_ADDR + NUM_REGS);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t                        r_state;
    logic [MSG_W-1:0]                  r_send_msg;
    logic [NUM_REGS*PAYLOAD_SIZE-1:0]  r_cfg;

    logic [ADDR_SIZE-1:0]    w_addr;
    logic                    w_wr;
    logic [PAYLOAD_SIZE-1:0] w_payload;
    logic [ADDR_SIZE:0]      w_addr_ext;
    logic [ADDR_SIZE:0]      w_off;
    logic                    w_hit;
    logic                    w_send_val;
    logic                    w_recv_rdy;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_write;
    logic [PAYLOAD_SIZE-1:0] w_rd_data;
    logic [MSG_W-1:0]        w_next_msg;

    assign w_addr     = recv.msg[MSG_W-1 -: ADDR_SIZE];
    assign w_wr       = recv.msg[PAYLOAD_SIZE];
    assign w_payload  = recv.msg[PAYLOAD_SIZE-1:0];
    assign w_addr_ext = {1'b0, w_addr};
    assign w_off      = w_addr_ext - WIN_LO;
    assign w_hit      = (w_addr_ext >= WIN_LO) && (w_addr_ext < WIN_HI);

    assign w_send_val = (r_state == FULL);
    assign w_recv_rdy = !w_send_val || send.rdy;
    assign w_accept   = recv.val && w_recv_rdy;
    assign w_write    = w_accept && w_hit && w_wr;
    assign w_load     = w_accept && !(w_hit && w_wr);

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_off == (ADDR_SIZE+1)'(i)) begin
                w_rd_data = r_cfg[i*PAYLOAD_SIZE +: PAYLOAD_SIZE];
            end
        end
    end

    // Read hits answer with the stored value; misses forward the message verbatim.
    assign w_next_msg = w_hit ? {w_addr, 1'b0, w_rd_data} : recv.msg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_send_msg <= '0;
            r_cfg      <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_write && (w_off == (ADDR_SIZE+1)'(i))) begin
                    r_cfg[i*PAYLOAD_SIZE +: PAYLOAD_SIZE] <= w_payload;
                end
            end
            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        r_state    <= FULL;
                        r_send_msg <= w_next_msg;
                    end
                end
                FULL: begin
                    if (send.rdy) begin
                        if (w_load) begin
                            r_send_msg <= w_next_msg;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign recv.rdy = w_recv_rdy;
    assign send.val = w_send_val;
    assign send.msg = r_send_msg;
    assign cfg_out  = r_cfg;

endmodule

// File: tb/tb_config_reg_file.sv
// Directed bench for config_reg_file: default window plus a BASE_ADDR=4 instance
// for the relocated-window case.
module tb_config_reg_file;

    logic        clk;
    logic        reset;
    logic [31:0] cfg0;
    logic [31:0] cfg4;
    int          checks;
    int          failures;

    config_reg_file_if #(.MSG_W(13)) r0_if ();
    config_reg_file_if #(.MSG_W(13)) s0_if ();
    config_reg_file_if #(.MSG_W(13)) r4_if ();
    config_reg_file_if #(.MSG_W(13)) s4_if ();

    config_reg_file #(.ADDR_SIZE(4), .PAYLOAD_SIZE(8), .NUM_REGS(4), .BASE_ADDR(0)) u_dut0 (
        .clk     (clk),
        .reset   (reset),
        .recv    (r0_if),
        .send    (s0_if),
        .cfg_out (cfg0)
    );

    config_reg_file #(.ADDR_SIZE(4), .PAYLOAD_SIZE(8), .NUM_REGS(4), .BASE_ADDR(4)) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .recv    (r4_if),
        .send    (s4_if),
        .cfg_out (cfg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        r0_if.val = 1'b1;
        r0_if.msg = 13'b0001_1_11111111;
        s0_if.rdy = 1'b1;
        r4_if.val = 1'b0;
        r4_if.msg = '0;
        s4_if.rdy = 1'b1;

        // Reset held two cycles with a write presented
        tick();
        tick();
        check("rst_cfg", cfg0, 32'h0);
        check("rst_send_val", {31'b0, s0_if.val}, 32'd0);
        check("rst_send_msg", {19'b0, s0_if.msg}, 32'h0);
        check("rst_cfg4", cfg4, 32'h0);
        reset     = 1'b0;
        r0_if.val = 1'b0;
        check("rst_recv_rdy", {31'b0, r0_if.rdy}, 32'd1);

        // Write hit reg1 = 0x55
        r0_if.val = 1'b1;
        r0_if.msg = 13'b0001_1_01010101;
        tick();
        check("wr_cfg", cfg0, 32'h0000_5500);
        check("wr_send_val", {31'b0, s0_if.val}, 32'd0);

        // Read hit reg1, back to back with the write
        r0_if.msg = 13'b0001_0_00000000;
        tick();
        check("rd_send_val", {31'b0, s0_if.val}, 32'd1);
        check("rd_send_msg", {19'b0, s0_if.msg}, 32'h255);

        // Miss forward; same message lands on reg1 of the BASE_ADDR=4 instance
        r0_if.msg = 13'b0101_1_10101010;
        r4_if.val = 1'b1;
        r4_if.msg = 13'b0101_1_10101010;
        tick();
        r4_if.val = 1'b0;
        check("miss_send_val", {31'b0, s0_if.val}, 32'd1);
        check("miss_send_msg", {19'b0, s0_if.msg}, 32'hBAA);
        check("miss_cfg", cfg0, 32'h0000_5500);
        check("base4_cfg", cfg4, 32'h0000_AA00);
        check("base4_send_val", {31'b0, s4_if.val}, 32'd0);

        // Write hits drain the buffer while send_rdy=1
        r0_if.msg = 13'b0000_1_01010101;
        tick();
        check("wr0_cfg", cfg0, 32'h0000_5555);
        check("wr0_drain", {31'b0, s0_if.val}, 32'd0);
        r0_if.msg = 13'b0001_1_00000000;
        tick();
        check("wr1_cfg", cfg0, 32'h0000_0055);
        r0_if.msg = 13'b0010_1_10101010;
        tick();
        check("wr2_cfg", cfg0, 32'h00AA_0055);
        r0_if.msg = 13'b0011_1_00111100;
        tick();
        check("wr3_cfg", cfg0, 32'h3CAA_0055);

        // Top of window read with junk payload, then first address past the window
        r0_if.msg = 13'b0011_0_11111111;
        tick();
        check("rd3_send_msg", {19'b0, s0_if.msg}, 32'h63C);
        r0_if.msg = 13'b0100_0_11110000;
        tick();
        check("edge_miss_msg", {19'b0, s0_if.msg}, 32'h8F0);
        check("edge_miss_cfg", cfg0, 32'h3CAA_0055);
        r0_if.msg = 13'b0011_1_00000000;
        tick();
        check("wr3_clr_cfg", cfg0, 32'h00AA_0055);
        check("wr3_clr_val", {31'b0, s0_if.val}, 32'd0);

        // Backpressure: first read is stalled, second read waits
        s0_if.rdy = 1'b0;
        r0_if.msg = 13'b0000_0_00000000;
        tick();
        check("bp_first_msg", {19'b0, s0_if.msg}, 32'h055);
        r0_if.msg = 13'b0010_0_00000000;
        for (int c = 0; c < 3; c++) begin
            check("bp_recv_rdy", {31'b0, r0_if.rdy}, 32'd0);
            tick();
            check("bp_hold_msg", {19'b0, s0_if.msg}, 32'h055);
            check("bp_hold_val", {31'b0, s0_if.val}, 32'd1);
        end
        s0_if.rdy = 1'b1;
        #1;
        check("bp_release_rdy", {31'b0, r0_if.rdy}, 32'd1);
        tick();
        check("bp_second_msg", {19'b0, s0_if.msg}, 32'h4AA);
        check("bp_second_val", {31'b0, s0_if.val}, 32'd1);

        // Reset mid-operation with a FULL buffer and a write presented
        s0_if.rdy = 1'b0;
        r0_if.val = 1'b0;
        check("pre_rst_cfg", cfg0, 32'h00AA_0055);
        reset     = 1'b1;
        r0_if.val = 1'b1;
        r0_if.msg = 13'b0000_1_11111111;
        tick();
        reset     = 1'b0;
        r0_if.val = 1'b0;
        check("mid_rst_val", {31'b0, s0_if.val}, 32'd0);
        check("mid_rst_msg", {19'b0, s0_if.msg}, 32'h0);
        check("mid_rst_cfg", cfg0, 32'h0);
        check("mid_rst_recv_rdy", {31'b0, r0_if.rdy}, 32'd1);
        tick();
        check("post_rst_cfg", cfg0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_reg_file.md
# config_reg_file

Parametrised bank of `NUM_REGS` configuration registers that occupies a contiguous address window `[BASE_ADDR, BASE_ADDR+NUM_REGS)` on the configuration message chain. It sits between the configuration message source and the next chained configuration block. In-window writes update a register. In-window reads return the register value downstream. Out-of-window messages pass through unchanged. Both sides use val/rdy handshakes with a one-entry output buffer, so the block can be daisy-chained without combinational paths from `send_rdy` to `send_val`.

## Interface
- `ADDR_SIZE`, 4, address field width.
- `PAYLOAD_SIZE`, 8, data field and register width.
- `NUM_REGS`, 4, number of registers; ≥1.
- `BASE_ADDR`, 0, first owned address. Constraint: `BASE_ADDR+NUM_REGS <= 2**ADDR_SIZE`.
- Message layout, MSB→LSB: `{addr[ADDR_SIZE-1:0], wr[0], payload[PAYLOAD_SIZE-1:0]}`. Width `MSG_W = ADDR_SIZE+PAYLOAD_SIZE+1`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `recv_msg`  in  MSG_W  incoming config message.
- `recv_val`  in  1  `recv_msg` valid.
- `recv_rdy`  out  1  block can accept a message this cycle.
- `send_msg`  out  MSG_W  outgoing message (read response or forwarded message).
- `send_val`  out  1  `send_msg` valid.
- `send_rdy`  in  1  downstream accepts `send_msg`.
- `cfg_out`  out  NUM_REGS*PAYLOAD_SIZE  register contents; reg i occupies bits `[i*PAYLOAD_SIZE +: PAYLOAD_SIZE]`.

## Operation
- Accept: a message is accepted when `recv_val && recv_rdy`.
- `recv_rdy = !send_val || send_rdy`. The accept condition is the same for every message type.
- Hit: `addr >= BASE_ADDR && addr < BASE_ADDR+NUM_REGS`.
  - Compare at ADDR_SIZE+1 bits so the window end never wraps.
  - Index is `addr - BASE_ADDR`.
- Write hit (`wr=1`): reg[index] ← payload.
  - No output message; the output buffer is unaffected by this message.
- Read hit (`wr=0`): load the output buffer with `{addr, 1'b0, reg[index]}`.
  - The incoming payload is ignored.
- Miss (any `wr`): load the output buffer with `recv_msg` unchanged. Registers are not modified.
- Output buffer has two states, EMPTY (`send_val=0`) and FULL (`send_val=1`).
  - EMPTY → FULL: on accepting a read hit or a miss.
  - FULL → EMPTY: on `send_rdy` with no new loading accept.
  - FULL → FULL: on `send_rdy` together with a loading accept. The new message replaces the old in the same cycle.
  - FULL, `send_rdy=0`: hold `send_msg` stable. `recv_rdy=0`.
- `cfg_out` is a direct view of the registers. There is no combinational path from `recv_msg` to `cfg_out`.
- Reset:
  - all registers ← 0;
  - `send_val` ← 0;
  - `send_msg` ← 0;
  - `recv_rdy` = 1 in the first cycle after reset.
- Reset mid-operation: a buffered message is dropped and registers clear. A message presented in the same cycle as reset is not accepted, and `recv_rdy` is ignored while reset is high.

## Timing
- Write latency: 1 cycle. The value is visible on `cfg_out` after the accepting edge.
- Read/forward latency: 1 cycle. `send_val` rises after the accepting edge.
- Write followed by read of the same register on consecutive cycles: the read returns the newly written value.
- Sustained throughput: 1 message/cycle while `send_rdy=1`.
- Write hits still accept when the buffer is FULL only if `send_rdy=1`. Writes are not reordered around a stalled response.

## Test plan
Defaults apply (ADDR_SIZE=4, PAYLOAD_SIZE=8, NUM_REGS=4, BASE_ADDR=0, 13-bit messages).
- Reset: hold `reset=1` for 2 cycles with `recv_val=1`, `recv_msg=13'b0001_1_11111111` → `cfg_out=32'h0`, `send_val=0`, `send_msg=0`, no register written.
- Write hit: send `13'b0001_1_01010101` with `send_rdy=1` → after one edge `cfg_out[15:8]=8'h55`, other bytes 0, `send_val` stays 0.
- Read hit: follow directly with `13'b0001_0_00000000` → next cycle `send_val=1`, `send_msg=13'b0001_0_01010101`.
- Miss forward: send `13'b0101_1_10101010` → next cycle `send_msg` equals the input unchanged and `cfg_out` is unchanged. Repeat with BASE_ADDR=4: the same message writes reg1 (`cfg_out[15:8]=8'hAA`).
- Backpressure:
  - Read reg0 with `send_rdy=0`, then present a second read → `recv_rdy=0` and `send_msg` stays stable for 3 cycles.
  - Raise `send_rdy` → the first response drains and the second is accepted the same cycle and appears next cycle.
- Reset mid-operation: with FULL buffer and `cfg_out=32'h00AA0055`, pulse `reset` for 1 cycle → `send_val=0`, `cfg_out=0` after that edge; `recv_rdy=1` the following cycle.
